// File: rtl/parking_pkg.sv
// parking_pkg: gate state encoding, default timing constants and hour helper for the parking gate controller
package parking_pkg;

    typedef enum logic [2:0] {
        GATE_IDLE,
        GATE_CHECK,
        GATE_OPEN,
        GATE_WAIT_CLEAR,
        GATE_DENY
    } gate_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_BARRIER_CYCLES  = 8;
    localparam int DEF_CYCLES_PER_HOUR = 200;
    localparam logic [4:0] LAST_HOUR   = 5'd23;

    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h == LAST_HOUR) ? 5'd0 : h + 5'd1;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchronizer plus debounce counter with registered rise/fall strobes
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          differ;
    logic          accept;

    // cnt tracks consecutive synchronized samples that disagree with the accepted level
    assign differ = sync[1] != level;
    assign accept = differ && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            cnt   <= (differ && !accept) ? cnt + 1'b1 : '0;
            level <= accept ? sync[1] : level;
            rise  <= accept && sync[1];
            fall  <= accept && !sync[1];
        end
    end

endmodule

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: debounced entry/exit lane FSMs driving barriers, event pulses and a time-of-day counter
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int BARRIER_CYCLES  = DEF_BARRIER_CYCLES,
    parameter int CYCLES_PER_HOUR = DEF_CYCLES_PER_HOUR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_sensor,
    input  logic       entry_is_uni,
    input  logic       exit_sensor,
    input  logic       exit_is_uni,
    input  logic       uni_is_vacated_space,
    input  logic       free_is_vacated_space,
    output logic       car_entered,
    output logic       is_uni_car_entered,
    output logic       car_exited,
    output logic       is_uni_car_exited,
    output logic [4:0] hour,
    output logic       entry_barrier_open,
    output logic       exit_barrier_open,
    output logic       entry_denied
);
    localparam int BW = $clog2(BARRIER_CYCLES + 1);
    localparam int PW = $clog2(CYCLES_PER_HOUR + 1);

    logic          e_level, e_rise, e_fall;
    logic          x_level, x_rise, x_fall;
    logic          x_rise_d;
    logic          e_cls, x_cls, e_ok, e_done, x_done;
    logic          unused_fall;
    logic [BW-1:0] e_cnt, x_cnt;
    logic [PW-1:0] presc;
    gate_state_t   e_state, e_next, x_state, x_next;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_db (
        .clk(clk), .rst(rst), .raw(entry_sensor),
        .level(e_level), .rise(e_rise), .fall(e_fall)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_db (
        .clk(clk), .rst(rst), .raw(exit_sensor),
        .level(x_level), .rise(x_rise), .fall(x_fall)
    );

    assign unused_fall        = e_fall | x_fall;
    assign e_ok               = e_cls ? uni_is_vacated_space : free_is_vacated_space;
    assign e_done             = e_cnt == BW'(BARRIER_CYCLES - 1);
    assign x_done             = x_cnt == BW'(BARRIER_CYCLES - 1);
    assign entry_barrier_open = e_state == GATE_OPEN;
    assign exit_barrier_open  = x_state == GATE_OPEN;
    assign entry_denied       = e_state == GATE_DENY;

    // Exit has no capacity check; the delayed rise stands in for CHECK so both lanes share timing
    always_comb begin
        e_next = e_state;
        x_next = x_state;
        e_next = (e_state == GATE_IDLE && e_rise) ? GATE_CHECK :
                 (e_state == GATE_CHECK) ? (e_ok ? GATE_OPEN : GATE_DENY) :
                 (e_state == GATE_OPEN && e_done) ? GATE_WAIT_CLEAR :
                 ((e_state == GATE_WAIT_CLEAR || e_state == GATE_DENY) && !e_level) ? GATE_IDLE :
                 e_state;
        x_next = (x_state == GATE_IDLE && x_rise_d) ? GATE_OPEN :
                 (x_state == GATE_OPEN && x_done) ? GATE_WAIT_CLEAR :
                 (x_state == GATE_WAIT_CLEAR && !x_level) ? GATE_IDLE :
                 x_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_state            <= GATE_IDLE;
            x_state            <= GATE_IDLE;
            e_cnt              <= '0;
            x_cnt              <= '0;
            e_cls              <= 1'b0;
            x_cls              <= 1'b0;
            x_rise_d           <= 1'b0;
            car_entered        <= 1'b0;
            is_uni_car_entered <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_exited  <= 1'b0;
            presc              <= '0;
            hour               <= '0;
        end else begin
            e_state            <= e_next;
            x_state            <= x_next;
            e_cnt              <= (e_state == GATE_OPEN) ? e_cnt + 1'b1 : '0;
            x_cnt              <= (x_state == GATE_OPEN) ? x_cnt + 1'b1 : '0;
            e_cls              <= (e_state == GATE_IDLE && e_rise) ? entry_is_uni : e_cls;
            x_cls              <= (x_state == GATE_IDLE && x_rise) ? exit_is_uni : x_cls;
            x_rise_d           <= x_rise;
            car_entered        <= e_state == GATE_CHECK && e_ok;
            is_uni_car_entered <= (e_state == GATE_CHECK && e_ok) ? e_cls : is_uni_car_entered;
            car_exited         <= x_state == GATE_IDLE && x_rise_d;
            is_uni_car_exited  <= (x_state == GATE_IDLE && x_rise_d) ? x_cls : is_uni_car_exited;
            presc              <= (presc == PW'(CYCLES_PER_HOUR - 1)) ? '0 : presc + 1'b1;
            hour               <= (presc == PW'(CYCLES_PER_HOUR - 1)) ? next_hour(hour) : hour;
        end
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: randomized stimulus against a timestamp-based lane model with a pulse scoreboard
module tb_parking_gate_controller;
    localparam int DB  = 4;
    localparam int BC  = 8;
    localparam int CPH = 10;
    localparam int N   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic entry_sensor = 1'b0, entry_is_uni = 1'b0, exit_sensor = 1'b0, exit_is_uni = 1'b0;
    logic uni_is_vacated_space = 1'b0, free_is_vacated_space = 1'b0;
    logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
    logic entry_barrier_open, exit_barrier_open, entry_denied;
    logic [4:0] hour;

    typedef struct packed {int at; logic cls;} ev_t;
    ev_t q0[$];
    ev_t q1[$];

    logic raw [2][N];
    logic uni [2][N];
    logic lvl [2][N];
    logic rise [2][N];
    logic xb [2][N];
    logic xu [2][N];
    logic uf [N];
    logic ff [N];
    logic rst_at [N];
    logic xd [N];
    int   xh [N];

    int   f;
    int   sr [2];
    logic sok [2];
    logic scls [2];
    logic held [2];
    int   g = 0;
    int   checks = 0;
    int   failures = 0;

    parking_gate_controller #(.DEBOUNCE_CYCLES(DB), .BARRIER_CYCLES(BC), .CYCLES_PER_HOUR(CPH)) dut (
        .clk(clk), .rst(rst),
        .entry_sensor(entry_sensor), .entry_is_uni(entry_is_uni),
        .exit_sensor(exit_sensor), .exit_is_uni(exit_is_uni),
        .uni_is_vacated_space(uni_is_vacated_space), .free_is_vacated_space(free_is_vacated_space),
        .car_entered(car_entered), .is_uni_car_entered(is_uni_car_entered),
        .car_exited(car_exited), .is_uni_car_exited(is_uni_car_exited),
        .hour(hour),
        .entry_barrier_open(entry_barrier_open), .exit_barrier_open(exit_barrier_open),
        .entry_denied(entry_denied)
    );

    always #5 clk = ~clk;
    always @(posedge clk) g++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, g, act, exp);
        end
    endtask

    // synchronized sample seen by the debouncer at edge m: raw two edges earlier, zero right after reset
    function automatic logic sample(int l, int m);
        return (rst_at[m-1] || rst_at[m-2]) ? 1'b0 : raw[l][m-2];
    endfunction

    task automatic push(int l, int n, logic c);
        ev_t e;
        e.at = n;
        e.cls = c;
        if (l == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // record inputs present at edge n and derive every expected output after that edge
    task automatic apply(int n);
        raw[0][n] = entry_sensor;
        raw[1][n] = exit_sensor;
        uni[0][n] = entry_is_uni;
        uni[1][n] = exit_is_uni;
        uf[n] = uni_is_vacated_space;
        ff[n] = free_is_vacated_space;
        rst_at[n] = rst;
        if (rst) begin
            f = n + 1;
            q0.delete();
            q1.delete();
            xd[n] = 1'b0;
            xh[n] = 0;
            for (int l = 0; l < 2; l++) begin
                sr[l] = -1;
                sok[l] = 1'b0;
                held[l] = 1'b0;
                lvl[l][n] = 1'b0;
                rise[l][n] = 1'b0;
                xb[l][n] = 1'b0;
                xu[l][n] = 1'b0;
            end
        end else begin
            xh[n] = ((n - f + 1) / CPH) % 24;
            for (int l = 0; l < 2; l++) begin
                logic prev, flip;
                prev = lvl[l][n-1];
                flip = (n - DB + 1 >= f);
                if (flip)
                    for (int k = 0; k < DB; k++) flip &= (sample(l, n - k) != prev);
                lvl[l][n] = flip ? !prev : prev;
                rise[l][n] = flip && !prev;
                if (sr[l] >= 0) begin
                    if (n >= sr[l] + (sok[l] ? BC + 3 : 3) && !lvl[l][n-1]) sr[l] = -1;
                end else if (rise[l][n-1]) begin
                    sr[l] = n - 1;
                end
                if (sr[l] >= 0 && n == sr[l] + 1) scls[l] = uni[l][n];
                if (sr[l] >= 0 && n == sr[l] + 2) begin
                    sok[l] = (l == 1) || (scls[l] ? uf[n] : ff[n]);
                    if (sok[l]) begin
                        held[l] = scls[l];
                        push(l, n, scls[l]);
                    end
                end
                xb[l][n] = sr[l] >= 0 && sok[l] && n >= sr[l] + 2 && n <= sr[l] + BC + 1;
                xu[l][n] = held[l];
                if (l == 0) xd[n] = sr[0] >= 0 && !sok[0] && n >= sr[0] + 2;
            end
        end
    endtask

    task automatic drive(logic es, logic xs, logic eu, logic xcls, logic u, logic fr, logic r);
        @(negedge clk);
        #1;
        entry_sensor = es;
        exit_sensor = xs;
        entry_is_uni = eu;
        exit_is_uni = xcls;
        uni_is_vacated_space = u;
        free_is_vacated_space = fr;
        rst = r;
        apply(g + 1);
    endtask

    task automatic pulse_chk(int l, logic p, logic c, int n);
        ev_t e;
        int sz;
        string nm;
        sz = (l == 0) ? q0.size() : q1.size();
        nm = (l == 0) ? "entry_pulse" : "exit_pulse";
        if (p) begin
            if (sz == 0) chk(nm, p, 0);
            else begin
                if (l == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk({nm, "_edge"}, n, e.at);
                chk({nm, "_cls"}, c, e.cls);
            end
        end else if (sz > 0) begin
            e = (l == 0) ? q0[0] : q1[0];
            if (e.at <= n) begin
                chk(nm, p, 1);
                if (l == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        int n;
        n = g;
        if (n > 0) begin
            chk("hour", hour, xh[n]);
            chk("entry_barrier", entry_barrier_open, xb[0][n]);
            chk("exit_barrier", exit_barrier_open, xb[1][n]);
            chk("entry_denied", entry_denied, xd[n]);
            chk("is_uni_entered", is_uni_car_entered, xu[0][n]);
            chk("is_uni_exited", is_uni_car_exited, xu[1][n]);
            pulse_chk(0, car_entered, is_uni_car_entered, n);
            pulse_chk(1, car_exited, is_uni_car_exited, n);
        end
    end

    initial begin
        int hold [2];
        logic rv [2];
        apply(1);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i <= 240; i++) begin
            drive(0, 0, 0, 0, 1, 1, 0);
            if (i == 10) chk("hour_first_step", hour, 1);
            if (i == 239) chk("hour_last", hour, 23);
            if (i == 240) chk("hour_wrap", hour, 0);
        end
        for (int i = 0; i < 20; i++) drive(1, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) drive(0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) drive(1, 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 12; i++) drive(0, 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 20; i++) drive(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 15; i++) drive(0, 0, 1, 0, 1, 1, 0);
        for (int i = 0; i < 11; i++) drive(1, 0, 1, 0, 1, 1, 0);
        chk("open_before_reset", entry_barrier_open, 1);
        drive(0, 0, 0, 0, 1, 1, 1);
        #1;
        chk("barrier_at_reset", entry_barrier_open, 0);
        chk("hour_at_reset", hour, 0);
        chk("pulse_at_reset", car_entered, 0);
        drive(0, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 1, 1, 0);
        hold[0] = 0;
        hold[1] = 3;
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            for (int l = 0; l < 2; l++) begin
                if (hold[l] == 0) begin
                    rv[l] = !rv[l];
                    hold[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 30));
                end else hold[l]--;
            end
            drive(rv[0], rv[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, i == 1000 || i == 1001);
        end
        for (int i = 0; i < 30; i++) drive(0, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        #2;
        chk("entry_queue_drained", q0.size(), 0);
        chk("exit_queue_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
